// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared core constants and the fetch entry type
package core_pkg;

   localparam int               XLEN         = 32;
   localparam logic [1:0]       RESP_OKAY    = 2'b00;
   localparam logic [XLEN-1:0]  NOP_INSTR    = 32'h0000_0013;
   localparam logic [2:0]       ARPROT_INSTR = 3'b100;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
      logic            fault;
   } fetch_entry_t;

   function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
      return addr & 32'hFFFF_FFFC;
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - prefetch FIFO with push/pop/flush and occupancy count
module fetch_fifo
   import core_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    push_i,
   input  fetch_entry_t            push_data_i,
   input  logic                    pop_i,
   input  logic                    flush_i,
   output fetch_entry_t            head_o,
   output logic                    empty_o,
   output logic [$clog2(DEPTH):0]  count_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   fetch_entry_t  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q;
   logic [AW-1:0] rd_ptr_q;
   logic [CW-1:0] count_q;

   // Entry storage is not reset; the top gates its outputs with empty_o.
   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
            wr_ptr_q        <= wr_ptr_q + 1'b1;
         end
         if (pop_i) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         count_q <= count_q + CW'(push_i) - CW'(pop_i);
      end
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign empty_o = (count_q == '0);
   assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage; bus-fault capture enabled by FETCH_FAULT_EN
module fetch_unit
   import core_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
   parameter int              FIFO_DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             redirect_valid,
   input  logic [XLEN-1:0]  redirect_pc,
   output logic [XLEN-1:0]  m_araddr,
   output logic [2:0]       m_arprot,
   output logic             m_arvalid,
   input  logic             m_arready,
   input  logic [XLEN-1:0]  m_rdata,
   input  logic [1:0]       m_rresp,
   input  logic             m_rvalid,
   output logic             m_rready,
   output logic             if_valid,
   input  logic             if_ready,
   output logic [XLEN-1:0]  if_instruction,
   output logic [XLEN-1:0]  if_pc,
   output logic             if_fault
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
   logic [XLEN-1:0] resp_pc_q, resp_pc_d;
   logic [XLEN-1:0] araddr_q, araddr_d;
   logic [CW-1:0]   outstanding_q, outstanding_d;
   logic [CW-1:0]   drop_q, drop_d;
   logic            arvalid_q, arvalid_d;
   logic            halt_q, halt_d;
   logic            rready_q;

   logic [CW-1:0]   fifo_count, count_next;
   logic [CW:0]     credit_used;
   logic [XLEN-1:0] base_pc, target_pc;
   logic            ar_hs, r_hs, ar_pending, push, pop, raise_ar;
   logic            fifo_empty, rsp_fault;
   fetch_entry_t    push_entry, head;

`ifdef FETCH_FAULT_EN
   assign rsp_fault = (m_rresp != RESP_OKAY);
`else
   logic unused_rresp;
   assign rsp_fault    = 1'b0;
   assign unused_rresp = ^(m_rresp ^ RESP_OKAY);
`endif

   assign target_pc  = word_align(redirect_pc);
   assign push_entry = '{pc: resp_pc_q, instr: (rsp_fault ? NOP_INSTR : m_rdata), fault: rsp_fault};

   always_comb begin
      ar_hs      = arvalid_q & m_arready;
      ar_pending = arvalid_q & ~m_arready;
      // Responses with nothing outstanding belong to a pre-reset transaction.
      r_hs       = m_rvalid & rready_q & (outstanding_q != '0);
      pop        = ~fifo_empty & if_ready & ~redirect_valid;
      push       = r_hs & (drop_q == '0) & ~redirect_valid;

      outstanding_d = outstanding_q + CW'(ar_hs) - CW'(r_hs);
      count_next    = redirect_valid ? '0 : (fifo_count + CW'(push) - CW'(pop));

      if (redirect_valid) begin
         drop_d = outstanding_d + CW'(ar_pending);
      end else if (r_hs && (drop_q != '0)) begin
         drop_d = drop_q - CW'(1);
      end else begin
         drop_d = drop_q;
      end

      halt_d      = redirect_valid ? 1'b0 : (halt_q | (push & rsp_fault));
      base_pc     = redirect_valid ? target_pc : fetch_pc_q;
      credit_used = {1'b0, outstanding_d} + {1'b0, count_next};
      // A new request is only raised once its response has a reserved FIFO slot.
      raise_ar    = ~ar_pending & ~halt_d & (credit_used < (CW+1)'(FIFO_DEPTH));

      arvalid_d  = ar_pending | raise_ar;
      araddr_d   = raise_ar ? base_pc : araddr_q;
      fetch_pc_d = raise_ar ? (base_pc + 32'd4) : base_pc;

      if (redirect_valid) begin
         resp_pc_d = target_pc;
      end else if (push) begin
         resp_pc_d = resp_pc_q + 32'd4;
      end else begin
         resp_pc_d = resp_pc_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         fetch_pc_q    <= RESET_PC;
         resp_pc_q     <= RESET_PC;
         araddr_q      <= RESET_PC;
         arvalid_q     <= 1'b0;
         outstanding_q <= '0;
         drop_q        <= '0;
         halt_q        <= 1'b0;
         rready_q      <= 1'b0;
      end else begin
         fetch_pc_q    <= fetch_pc_d;
         resp_pc_q     <= resp_pc_d;
         araddr_q      <= araddr_d;
         arvalid_q     <= arvalid_d;
         outstanding_q <= outstanding_d;
         drop_q        <= drop_d;
         halt_q        <= halt_d;
         rready_q      <= 1'b1;
      end
   end

   fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .push_i      (push),
      .push_data_i (push_entry),
      .pop_i       (pop),
      .flush_i     (redirect_valid),
      .head_o      (head),
      .empty_o     (fifo_empty),
      .count_o     (fifo_count)
   );

   assign m_araddr       = araddr_q;
   assign m_arvalid      = arvalid_q;
   assign m_arprot       = ARPROT_INSTR;
   assign m_rready       = rready_q;
   assign if_valid       = ~fifo_empty;
   assign if_instruction = fifo_empty ? '0 : head.instr;
   assign if_pc          = fifo_empty ? '0 : head.pc;
   assign if_fault       = ~fifo_empty & head.fault;

endmodule
